ext_wb_master: RTL and testbench
================================

EXT_WB_MASTER -- requirements
Module: ext_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles (>=2) a bus cycle may wait for wb_ack_i/wb_err_i.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- ext_tran_addr_i  in  32  byte address
- ext_tran_data_i  in  32  write data, LSB-justified
- ext_tran_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- ext_tran_start_i  in  1  one-cycle start pulse
- ext_tran_write_i  in  1  1 write, 0 read
- ext_tran_clear_i  in  1  acknowledge/clear of completed transaction
- ext_tran_data_o  out  32  read data, LSB-justified, zero-extended
- ext_tran_ready_o  out  1  transaction complete (sticky)
- ext_tran_err_o  out  1  transaction failed (sticky)
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls
- wb_adr_o  out  32  word address, bits [1:0] always 0
- wb_dat_o  out  32  write data, lane-replicated
- wb_sel_o  out  4  byte enables
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i  in  1 each  slave termination
REQ-003 Clock and reset SHALL be exactly one clock, clk_i, and one reset, rst_i, asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, BUS, DONE.
REQ-005 IDLE: start_i=1 at an edge SHALL latch addr/data/size/write; next state BUS if legal, else DONE with err=1, no bus cycle.
REQ-006 Illegal SHALL mean size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-007 wb_cyc_o=wb_stb_o=1 SHALL hold for exactly the cycles in BUS; wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o SHALL stay stable throughout.
REQ-008 wb_sel_o: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
REQ-009 wb_dat_o: byte {4{data[7:0]}}; half {2{data[15:0]}}; word data.
REQ-010 BUS, wb_ack_i=1 SHALL go to DONE; on a read, ext_tran_data_o SHALL take the selected lane(s) shifted to bit 0, zero-extended.
REQ-011 BUS, wb_err_i=1 (with or without ack) SHALL go to DONE with err=1; data_o unchanged.
REQ-012 BUS SHALL count cycles; after TIMEOUT_CYCLES cycles without ack/err, SHALL go to DONE with err=1.
REQ-013 Latency: start sampled at edge N -> cyc high after N; ack sampled at edge M -> cyc low and ready high after M.
REQ-014 ext_tran_ready_o SHALL be 1 exactly while in DONE; ext_tran_err_o only set on entry to DONE, cleared on leaving it.
REQ-015 DONE, clear_i=1 SHALL return to IDLE, zero ready/err; data_o SHALL hold until the next completed read.
REQ-016 start_i in BUS or DONE SHALL be ignored (not queued); clear_i in IDLE or BUS SHALL be ignored.
REQ-017 start_i and clear_i together in DONE: clear wins, start dropped; together in IDLE: start accepted.
REQ-018 wb_ack_i/wb_err_i outside BUS SHALL be ignored.

Reset
REQ-019 rst_i=1 SHALL immediately force IDLE and all outputs to 0, including wb_cyc_o/wb_stb_o mid-BUS, and zero the timeout counter and latched command.
REQ-020 After rst_i deasserts, the first start_i SHALL be accepted no earlier than the first clock edge with rst_i=0.

Verification
REQ-021 Word write addr 0x0000_1004, data 0xDEADBEEF, ack after 3 cycles -> adr 0x1004, sel 1111, dat 0xDEADBEEF, we=1, cyc high 3 cycles, ready=1, err=0.
REQ-022 Byte read addr 0x0000_2003, slave returns 0xAABBCCDD -> sel 1000, data_o 0x000000AA, ready=1; clear -> ready=0, data_o still 0xAA.
REQ-023 Half write addr 0x0000_0001 -> no cyc ever, ready=1 and err=1 one cycle after start; size=11 likewise.
REQ-024 TIMEOUT_CYCLES=16, no ack -> cyc high exactly 16 cycles, then ready=1, err=1; late ack ignored.
REQ-025 Start during BUS and during DONE -> ignored, single cycle performed; start+clear together in DONE -> back to IDLE, no new cycle.
REQ-026 rst_i pulsed mid-BUS, asynchronous to clk_i -> cyc/stb low immediately, ready/err 0; new start afterwards completes normally.

Source files
------------

// File: rtl/ext_wb_master.sv
// Single-transaction Wishbone classic master driven by an external command port.
// Handles byte/half/word lanes, alignment errors, slave errors and a bus timeout.
module ext_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ext_tran_addr_i,
  input  logic [31:0] ext_tran_data_i,
  input  logic [1:0]  ext_tran_size_i,
  input  logic        ext_tran_start_i,
  input  logic        ext_tran_write_i,
  input  logic        ext_tran_clear_i,
  output logic [31:0] ext_tran_data_o,
  output logic        ext_tran_ready_o,
  output logic        ext_tran_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q;
  logic [1:0]    alo_q;

  logic          legal_d;
  logic [3:0]    sel_d;
  logic [31:0]   wdat_d;
  logic [31:0]   sh_d;
  logic [31:0]   rdat_d;

  always_comb begin
    legal_d = 1'b1;
    sel_d   = 4'b1111;
    wdat_d  = ext_tran_data_i;
    unique case (ext_tran_size_i)
      2'b00: begin
        sel_d  = 4'b0001 << ext_tran_addr_i[1:0];
        wdat_d = {4{ext_tran_data_i[7:0]}};
      end
      2'b01: begin
        legal_d = ~ext_tran_addr_i[0];
        sel_d   = ext_tran_addr_i[1] ? 4'b1100 : 4'b0011;
        wdat_d  = {2{ext_tran_data_i[15:0]}};
      end
      2'b10: begin
        legal_d = (ext_tran_addr_i[1:0] == 2'b00);
      end
      default: begin
        legal_d = 1'b0;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then trim to the access size.
  always_comb begin
    sh_d = wb_dat_i >> {alo_q, 3'b000};
    unique case (size_q)
      2'b00:   rdat_d = {24'd0, sh_d[7:0]};
      2'b01:   rdat_d = {16'd0, sh_d[15:0]};
      default: rdat_d = sh_d;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      size_q           <= 2'b00;
      alo_q            <= 2'b00;
      ext_tran_data_o  <= '0;
      ext_tran_ready_o <= 1'b0;
      ext_tran_err_o   <= 1'b0;
      wb_cyc_o         <= 1'b0;
      wb_stb_o         <= 1'b0;
      wb_we_o          <= 1'b0;
      wb_adr_o         <= '0;
      wb_dat_o         <= '0;
      wb_sel_o         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ext_tran_start_i) begin
            size_q   <= ext_tran_size_i;
            alo_q    <= ext_tran_addr_i[1:0];
            wb_we_o  <= ext_tran_write_i;
            wb_adr_o <= {ext_tran_addr_i[31:2], 2'b00};
            wb_dat_o <= wdat_d;
            wb_sel_o <= sel_d;
            cnt_q    <= '0;
            if (legal_d) begin
              state_q  <= BUS;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
            end else begin
              state_q          <= DONE;
              ext_tran_ready_o <= 1'b1;
              ext_tran_err_o   <= 1'b1;
            end
          end
        end
        BUS: begin
          if (wb_err_i || wb_ack_i || cnt_q == TLAST) begin
            state_q          <= DONE;
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
            ext_tran_ready_o <= 1'b1;
            ext_tran_err_o   <= wb_err_i || !wb_ack_i;
            if (wb_ack_i && !wb_err_i && !wb_we_o) begin
              ext_tran_data_o <= rdat_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (ext_tran_clear_i) begin
            state_q          <= IDLE;
            ext_tran_ready_o <= 1'b0;
            ext_tran_err_o   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_wb_master.sv
// Directed self-checking bench for ext_wb_master with a short timeout.
module tb_ext_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = 2'b00;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dato;
  logic [3:0]  sel;
  logic [31:0] dati = '0;
  logic        ack = 1'b0;
  logic        werr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  int guard;

  ext_wb_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ext_tran_addr_i(addr),
    .ext_tran_data_i(wdata),
    .ext_tran_size_i(size),
    .ext_tran_start_i(start),
    .ext_tran_write_i(wr),
    .ext_tran_clear_i(clr),
    .ext_tran_data_o(rdata),
    .ext_tran_ready_o(ready),
    .ext_tran_err_o(err),
    .wb_cyc_o(cyc),
    .wb_stb_o(stb),
    .wb_we_o(we),
    .wb_adr_o(adr),
    .wb_dat_o(dato),
    .wb_sel_o(sel),
    .wb_dat_i(dati),
    .wb_ack_i(ack),
    .wb_err_i(werr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] s, input logic w);
    addr = a; wdata = d; size = s; wr = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_rdy", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    #1 rst = 1'b0;

    // word write, ack on third bus cycle
    go(32'h0000_1004, 32'hDEAD_BEEF, 2'b10, 1'b1);
    chk("ww_adr", adr, 32'h0000_1004);
    chk("ww_sel", {28'd0, sel}, 32'hF);
    chk("ww_dat", dato, 32'hDEAD_BEEF);
    chk("ww_we", {31'd0, we}, 32'd1);
    chk("ww_stb", {31'd0, stb}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (cyc) cnt++;
      if (i == 2) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    chk("ww_cyc_len", cnt, 3);
    chk("ww_cyc_end", {31'd0, cyc}, 32'd0);
    chk("ww_rdy", {31'd0, ready}, 32'd1);
    chk("ww_err", {31'd0, err}, 32'd0);
    go(32'h0000_0100, 32'h1, 2'b10, 1'b0);
    chk("done_start_cyc", {31'd0, cyc}, 32'd0);
    chk("done_start_rdy", {31'd0, ready}, 32'd1);
    clear();
    chk("ww_clr_rdy", {31'd0, ready}, 32'd0);
    tick();
    chk("ww_idle_cyc", {31'd0, cyc}, 32'd0);

    // byte read from lane 3
    go(32'h0000_2003, 32'h0, 2'b00, 1'b0);
    chk("br_sel", {28'd0, sel}, 32'h8);
    chk("br_adr", adr, 32'h0000_2000);
    chk("br_we", {31'd0, we}, 32'd0);
    dati = 32'hAABB_CCDD;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("br_data", rdata, 32'h0000_00AA);
    chk("br_rdy", {31'd0, ready}, 32'd1);
    clear();
    chk("br_clr_rdy", {31'd0, ready}, 32'd0);
    chk("br_hold", rdata, 32'h0000_00AA);

    // misaligned half and reserved size
    go(32'h0000_0001, 32'h0, 2'b01, 1'b1);
    chk("mh_cyc", {31'd0, cyc}, 32'd0);
    chk("mh_rdy", {31'd0, ready}, 32'd1);
    chk("mh_err", {31'd0, err}, 32'd1);
    clear();
    chk("mh_clr_err", {31'd0, err}, 32'd0);
    go(32'h0000_0000, 32'h0, 2'b11, 1'b0);
    chk("rs_cyc", {31'd0, cyc}, 32'd0);
    chk("rs_err", {31'd0, err}, 32'd1);
    clear();

    // half write upper lane, half read upper lane
    go(32'h0000_0032, 32'h0000_1234, 2'b01, 1'b1);
    chk("hw_sel", {28'd0, sel}, 32'hC);
    chk("hw_dat", dato, 32'h1234_1234);
    chk("hw_adr", adr, 32'h0000_0030);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("hw_err", {31'd0, err}, 32'd0);
    chk("hw_nodata", rdata, 32'h0000_00AA);
    clear();
    go(32'h0000_0042, 32'h0, 2'b01, 1'b0);
    chk("hr_sel", {28'd0, sel}, 32'hC);
    dati = 32'h5566_7788;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("hr_data", rdata, 32'h0000_5566);
    clear();
    go(32'h0000_0050, 32'h0000_0077, 2'b00, 1'b1);
    chk("bw_sel", {28'd0, sel}, 32'h1);
    chk("bw_dat", dato, 32'h7777_7777);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    clear();

    // timeout
    go(32'h0000_3000, 32'h0, 2'b10, 1'b0);
    cnt = 0;
    guard = 0;
    while (!ready && guard < 40) begin
      if (cyc) cnt++;
      tick();
      guard++;
    end
    chk("to_bound", {31'd0, ready}, 32'd1);
    chk("to_cyc_len", cnt, 16);
    chk("to_err", {31'd0, err}, 32'd1);
    dati = 32'hFFFF_FFFF;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("to_late_err", {31'd0, err}, 32'd1);
    chk("to_late_data", rdata, 32'h0000_5566);
    chk("to_late_cyc", {31'd0, cyc}, 32'd0);
    clear();

    // slave error
    go(32'h0000_3004, 32'h0, 2'b10, 1'b0);
    werr = 1'b1;
    ack = 1'b1;
    tick();
    werr = 1'b0;
    ack = 1'b0;
    chk("se_err", {31'd0, err}, 32'd1);
    chk("se_data", rdata, 32'h0000_5566);
    clear();

    // start during BUS ignored; start+clear in DONE
    go(32'h0000_0010, 32'h0000_00A1, 2'b10, 1'b1);
    go(32'h0000_0020, 32'h0000_00B2, 2'b10, 1'b0);
    chk("sb_adr", adr, 32'h0000_0010);
    chk("sb_dat", dato, 32'h0000_00A1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("sb_rdy", {31'd0, ready}, 32'd1);
    clr = 1'b1;
    go(32'h0000_0020, 32'h0, 2'b10, 1'b0);
    clr = 1'b0;
    chk("sc_rdy", {31'd0, ready}, 32'd0);
    chk("sc_cyc", {31'd0, cyc}, 32'd0);
    tick();
    chk("sc_cyc2", {31'd0, cyc}, 32'd0);

    // asynchronous reset mid-BUS
    go(32'h0000_0040, 32'h0, 2'b10, 1'b0);
    chk("ar_cyc_pre", {31'd0, cyc}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_cyc", {31'd0, cyc}, 32'd0);
    chk("ar_stb", {31'd0, stb}, 32'd0);
    chk("ar_rdy", {31'd0, ready}, 32'd0);
    chk("ar_data", rdata, 32'd0);
    #2 rst = 1'b0;
    go(32'h0000_0044, 32'h0, 2'b00, 1'b0);
    chk("ar_new_sel", {28'd0, sel}, 32'h1);
    dati = 32'h0000_0042;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ar_new_rdy", {31'd0, ready}, 32'd1);
    chk("ar_new_err", {31'd0, err}, 32'd0);
    chk("ar_new_data", rdata, 32'h0000_0042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
